// File: rtl/md_sched_if.sv
// EX-side operation bus of the HI/LO multiply/divide scheduler.
interface md_sched_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_type;
  logic [31:0] op_src1;
  logic [31:0] op_src2;
  logic        flush;
  logic [31:0] rd_data;

  modport master (
    output op_valid, op_type, op_src1, op_src2, flush,
    input  op_ready, rd_data
  );

  modport slave (
    input  op_valid, op_type, op_src1, op_src2, flush,
    output op_ready, rd_data
  );
endinterface

// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: accepts one MULT/DIV/MTxx/MFxx at a time,
// sequences the external multiplier and divider, and owns HI and LO.
module md_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  md_sched_if.slave   ex,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_res,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_done,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e      state, stateNext;
  logic [2:0]  cnt, cntNext;
  logic [31:0] hiQ, hiNext;
  logic [31:0] loQ, loNext;
  logic [31:0] xQ, xNext;
  logic [31:0] yQ, yNext;
  logic        sgnQ, sgnNext;
  logic        divFirst, divFirstNext;
  logic        accept;

  assign ex.op_ready = (state == IDLE) && !ex.flush;
  assign accept      = ex.op_valid && ex.op_ready;
  assign busy        = (state != IDLE);
  assign hi          = hiQ;
  assign lo          = loQ;
  assign mul_x       = xQ;
  assign mul_y       = yQ;
  assign div_x       = xQ;
  assign div_y       = yQ;
  assign mul_signed  = sgnQ;
  assign div_signed  = sgnQ;

  // Flush always wins over a completing multiply count or a div_done.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    hiNext       = hiQ;
    loNext       = loQ;
    xNext        = xQ;
    yNext        = yQ;
    sgnNext      = sgnQ;
    divFirstNext = 1'b0;
    div_start    = 1'b0;
    div_cancel   = 1'b0;
    ex.rd_data   = '0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          xNext   = ex.op_src1;
          yNext   = ex.op_src2;
          sgnNext = (ex.op_type == OP_MULT) || (ex.op_type == OP_DIV);
          case (ex.op_type)
            OP_MULT, OP_MULTU: begin
              stateNext = MUL;
              cntNext   = MUL_LAT[2:0];
            end
            OP_DIV, OP_DIVU: begin
              if (ex.op_src2 != '0) begin
                stateNext    = DIV;
                divFirstNext = 1'b1;
              end
            end
            OP_MTHI: hiNext = ex.op_src1;
            OP_MTLO: loNext = ex.op_src1;
            OP_MFHI: ex.rd_data = hiQ;
            OP_MFLO: ex.rd_data = loQ;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (ex.flush) begin
          stateNext = IDLE;
        end else if (cnt == 3'd1) begin
          {hiNext, loNext} = mul_res;
          stateNext        = IDLE;
        end else begin
          cntNext = cnt - 3'd1;
        end
      end
      DIV: begin
        div_start = divFirst;
        if (ex.flush) begin
          div_cancel = 1'b1;
          stateNext  = IDLE;
        end else if (div_done) begin
          loNext    = div_s;
          hiNext    = div_r;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      hiQ      <= '0;
      loQ      <= '0;
      xQ       <= '0;
      yQ       <= '0;
      sgnQ     <= 1'b0;
      divFirst <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      hiQ      <= hiNext;
      loQ      <= loNext;
      xQ       <= xNext;
      yQ       <= yNext;
      sgnQ     <= sgnNext;
      divFirst <= divFirstNext;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: directed cases plus random HI/LO op streams
// checked against an arithmetic model, with behavioural multiplier/divider.
module tb_md_sched;

  localparam int MUL_LAT = 2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] hi, lo, mul_x, mul_y, div_x, div_y;
  logic        busy, mul_signed, div_start, div_cancel, div_signed, div_done;
  logic [63:0] mul_res;
  logic [31:0] div_s, div_r;

  md_sched_if exIf ();

  md_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ex         (exIf),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .mul_signed (mul_signed),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_res    (mul_res),
    .div_start  (div_start),
    .div_cancel (div_cancel),
    .div_signed (div_signed),
    .div_x      (div_x),
    .div_y      (div_y),
    .div_done   (div_done),
    .div_s      (div_s),
    .div_r      (div_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
  } acceptExp_t;

  typedef struct {
    int len;
    int starts;
    int cancels;
  } runExp_t;

  acceptExp_t acceptQ[$];
  runExp_t    runQ[$];

  int compared   = 0;
  int mismatched = 0;
  int strayPulses = 0;
  logic [31:0] refHi = '0;
  logic [31:0] refLo = '0;

  // Behavioural multiplier: one register stage gives MUL_LAT = 2.
  function automatic logic [63:0] mulModel(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  logic [63:0] mulPipe;
  always @(posedge clk) mulPipe <= mulModel(mul_x, mul_y, mul_signed);
  assign mul_res = mulPipe;

  // Behavioural divider: done arrives divLatency+1 cycles after the start edge.
  int   divLatency = 0;
  int   divCnt;
  logic divBusy;
  logic spurious = 1'b0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divBusy <= 1'b0;
      divCnt  <= 0;
      div_s   <= '0;
      div_r   <= '0;
    end else if (div_cancel) begin
      divBusy <= 1'b0;
    end else if (div_start) begin
      divBusy <= 1'b1;
      divCnt  <= divLatency;
      if (div_signed) begin
        div_s <= $signed(div_x) / $signed(div_y);
        div_r <= $signed(div_x) % $signed(div_y);
      end else begin
        div_s <= div_x / div_y;
        div_r <= div_x % div_y;
      end
    end else if (divBusy) begin
      if (divCnt == 0) divBusy <= 1'b0;
      else divCnt <= divCnt - 1;
    end
  end
  assign div_done = spurious || (divBusy && divCnt == 0);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops accept expectations on each transfer and busy-run expectations when busy drops.
  int runLen = 0, runStarts = 0, runCancels = 0;
  initial begin
    acceptExp_t e;
    runExp_t    r;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        runLen = 0; runStarts = 0; runCancels = 0;
      end else begin
        if (exIf.op_valid && exIf.op_ready) begin
          if (acceptQ.size() == 0) begin
            compared++; mismatched++;
            $display("[TB] FAIL unexpected accept: got accept, required none");
          end else begin
            e = acceptQ.pop_front();
            checkOutput("rd_data", exIf.rd_data, e.rd);
            checkOutput("hi@accept", hi, e.hi);
            checkOutput("lo@accept", lo, e.lo);
          end
        end
        if (busy) begin
          runLen++;
          runStarts  += int'(div_start);
          runCancels += int'(div_cancel);
        end else begin
          if (div_start || div_cancel) strayPulses++;
          if (runLen > 0) begin
            if (runQ.size() == 0) begin
              compared++; mismatched++;
              $display("[TB] FAIL unexpected busy run: got length %0d, required none", runLen);
            end else begin
              r = runQ.pop_front();
              checkOutput("busy length", runLen, r.len);
              checkOutput("div_start count", runStarts, r.starts);
              checkOutput("div_cancel count", runCancels, r.cancels);
            end
            runLen = 0; runStarts = 0; runCancels = 0;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                               input int lat, input int flushAt);
    acceptExp_t e;
    runExp_t    r;
    int opLen, waited;
    logic isDiv;
    logic signed [63:0] sa, sb;
    e.hi = refHi;
    e.lo = refLo;
    e.rd = (t == OP_MFHI) ? refHi : (t == OP_MFLO) ? refLo : 32'd0;
    acceptQ.push_back(e);
    isDiv = (t == OP_DIV) || (t == OP_DIVU);
    opLen = 0;
    if (t == OP_MULT || t == OP_MULTU) opLen = MUL_LAT;
    else if (isDiv && b != 0) opLen = lat + 2;
    if (flushAt > opLen) flushAt = 0;
    if (opLen > 0) begin
      r.len     = (flushAt > 0) ? flushAt : opLen;
      r.starts  = isDiv ? 1 : 0;
      r.cancels = (isDiv && flushAt > 0) ? 1 : 0;
      runQ.push_back(r);
    end
    if (flushAt == 0) begin
      case (t)
        OP_MULT: begin
          sa = $signed(a);
          sb = $signed(b);
          {refHi, refLo} = sa * sb;
        end
        OP_MULTU: {refHi, refLo} = {32'b0, a} * {32'b0, b};
        OP_DIV: if (b != 0) begin
          refLo = $signed(a) / $signed(b);
          refHi = $signed(a) % $signed(b);
        end
        OP_DIVU: if (b != 0) begin
          refLo = a / b;
          refHi = a % b;
        end
        OP_MTHI: refHi = a;
        OP_MTLO: refLo = a;
        default: ;
      endcase
    end
    divLatency     = lat;
    exIf.op_type   = t;
    exIf.op_src1   = a;
    exIf.op_src2   = b;
    exIf.op_valid  = 1'b1;
    @(posedge clk); #1;
    exIf.op_valid  = 1'b0;
    if (flushAt > 0) begin
      repeat (flushAt - 1) begin @(posedge clk); #1; end
      exIf.flush = 1'b1;
      @(posedge clk); #1;
      exIf.flush = 1'b0;
    end else begin
      repeat (opLen) begin @(posedge clk); #1; end
    end
    waited = 0;
    while (busy && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (busy) begin
      compared++; mismatched++;
      $display("[TB] FAIL busy timeout: got busy after 200 cycles, required idle");
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  t;
    logic [31:0] a, b;
    int lat, fl;
    exIf.op_valid = 1'b0;
    exIf.op_type  = '0;
    exIf.op_src1  = '0;
    exIf.op_src2  = '0;
    exIf.flush    = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #3;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset op_ready", exIf.op_ready, 1);
    checkOutput("reset hi", hi, 0);
    checkOutput("reset lo", lo, 0);
    checkOutput("reset rd_data", exIf.rd_data, 0);
    checkOutput("reset div_start", div_start, 0);
    checkOutput("reset div_cancel", div_cancel, 0);
    checkOutput("reset operands", {mul_x, div_y}, 0);
    checkOutput("reset signed", {mul_signed, div_signed}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
    applyStimulus(OP_MFHI, 0, 0, 0, 0);
    applyStimulus(OP_MFLO, 0, 0, 0, 0);
    applyStimulus(OP_MTHI, 32'h11, 0, 0, 0);
    applyStimulus(OP_MTLO, 32'h22, 0, 0, 0);
    applyStimulus(OP_DIV, 32'd50, 32'd0, 3, 0);
    applyStimulus(OP_MFHI, 0, 0, 0, 0);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 30, 0);
    applyStimulus(OP_MFLO, 0, 0, 0, 0);
    applyStimulus(OP_DIV, 32'd1000, 32'd7, 5, 7);
    applyStimulus(OP_MFHI, 0, 0, 0, 0);
    applyStimulus(OP_MFLO, 0, 0, 0, 0);

    exIf.flush    = 1'b1;
    exIf.op_valid = 1'b1;
    exIf.op_type  = OP_MTLO;
    exIf.op_src1  = 32'h999;
    #1 checkOutput("op_ready under idle flush", exIf.op_ready, 0);
    @(posedge clk); #1;
    checkOutput("lo after idle flush", lo, refLo);
    exIf.flush    = 1'b0;
    exIf.op_valid = 1'b0;

    spurious = 1'b1;
    @(posedge clk); #1;
    spurious = 1'b0;
    applyStimulus(OP_MFHI, 0, 0, 0, 0);
    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 0, 0, 0);
    applyStimulus(OP_MFHI, 0, 0, 0, 0);
    applyStimulus(OP_MTLO, 32'd5, 0, 0, 0);
    applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 0, 0);
    applyStimulus(OP_MFHI, 0, 0, 0, 0);
    applyStimulus(OP_MFLO, 0, 0, 0, 0);

    $display("[TB] random stream");
    for (int i = 0; i < 300; i++) begin
      t   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = 0;
      if (t == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat = $urandom_range(0, 12);
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
      if ($urandom_range(0, 7) == 0) begin
        spurious = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b0;
      end
      applyStimulus(t, a, b, lat, fl);
    end

    $display("[TB] reset during divide");
    applyStimulus(OP_MTHI, 32'hA5A5_5A5A, 0, 0, 0);
    applyStimulus(OP_MTLO, 32'h0F0F_F0F0, 0, 0, 0);
    acceptQ.push_back('{hi: refHi, lo: refLo, rd: 32'd0});
    divLatency    = 30;
    exIf.op_type  = OP_DIVU;
    exIf.op_src1  = 32'd1000;
    exIf.op_src2  = 32'd3;
    exIf.op_valid = 1'b1;
    @(posedge clk); #1;
    exIf.op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async reset hi", hi, 0);
    checkOutput("async reset lo", lo, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset div_start", div_start, 0);
    checkOutput("async reset op_ready", exIf.op_ready, 1);
    refHi = '0;
    refLo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(OP_MULT, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0);
    applyStimulus(OP_MFHI, 0, 0, 0, 0);
    applyStimulus(OP_MFLO, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    checkOutput("accept queue drained", acceptQ.size(), 0);
    checkOutput("busy queue drained", runQ.size(), 0);
    checkOutput("stray divider pulses", strayPulses, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the EX stage. It accepts one HI/LO-class operation at a time (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO), sequences the external pipelined multiplier and iterative divider, owns the HI and LO architectural registers, and exports a busy/ready handshake that EX turns into its stall. It sits beside the ALU in EX; `mul`/`div` instances connect to its operand and result ports.

## Interface
- MUL_LAT, 2, cycles from multiplier operand presentation to valid `mul_res`; legal range 1..7

Ports:
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- op_valid  in  1  EX presents an operation
- op_ready  out  1  scheduler can accept; transfer when op_valid && op_ready
- op_type  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- op_src1  in  32  rs value (dividend, multiplicand, MTHI/MTLO data)
- op_src2  in  32  rt value (divisor, multiplier)
- flush  in  1  exception flush; aborts any in-flight op
- rd_data  out  32  MFHI/MFLO result, valid in the acceptance cycle
- hi, lo  out  32 each  architectural HI/LO
- busy  out  1  mul or div in flight
- mul_signed  out  1;  mul_x, mul_y  out  32 each  multiplier operands
- mul_res  in  64  multiplier product {hi,lo}
- div_start  out  1  one-cycle divider launch pulse
- div_cancel  out  1  one-cycle divider abort pulse
- div_signed  out  1;  div_x, div_y  out  32 each  divider operands
- div_done  in  1  divider result valid (one cycle)
- div_s, div_r  in  32 each  quotient, remainder

## Operation
- States: IDLE, MUL, DIV.
- op_ready = (state == IDLE) && !flush. busy = (state != IDLE).
- Accept in IDLE: op_src1/op_src2/signedness latched into operand registers, which drive mul_x/mul_y/div_x/div_y and the signed outputs continuously.
  - MULT/MULTU: go to MUL, counter loaded with MUL_LAT.
  - DIV/DIVU with op_src2 != 0: go to DIV.
  - DIV/DIVU with op_src2 == 0: stay IDLE; HI/LO unchanged; no div_start.
  - MTHI/MTLO: hi/lo <= op_src1 at that edge; stay IDLE.
  - MFHI/MFLO: rd_data = hi/lo combinationally in the acceptance cycle; no state change. rd_data = 0 for every other op_type.
- MUL: counter decrements each cycle. When counter == 1: {hi,lo} <= mul_res, go to IDLE.
- DIV: div_start = 1 in the first DIV cycle only. On div_done: lo <= div_s, hi <= div_r, go to IDLE. div_done is ignored outside DIV.
- flush:
  - In MUL: go to IDLE, no write.
  - In DIV: go to IDLE, no write, div_cancel = 1 for that cycle. Flush beats a simultaneous div_done or final MUL count.
  - In IDLE: blocks acceptance; no effect on HI/LO.
- Unsigned ops: signed outputs = 0. Widths are exact; no truncation beyond the 64-bit product split.

## Timing
- Reset (asynchronous, immediate): state IDLE, hi = lo = 0, operand registers = 0, counter = 0. Resulting outputs: busy 0, op_ready 1 (given flush = 0), div_start 0, div_cancel 0, rd_data 0, mul/div operand and signed outputs 0.
- Reset mid-MUL/DIV: abandons the op. No div_cancel is issued; the divider is reset by the same resetn.
- Acceptance in cycle 0:
  - MUL occupies cycles 1..MUL_LAT; HI/LO update at the end of cycle MUL_LAT; new value and busy = 0 in cycle MUL_LAT+1.
  - DIV: div_start in cycle 1; operands stable from cycle 1 until exit. If div_done is seen in cycle n, HI/LO are visible and op_ready = 1 in cycle n+1. A div_done in cycle 1 is legal.
  - MTHI/MTLO: new value visible in cycle 1. Back-to-back MTHI then MFHI returns the new value.
- The scheduler never accepts during MUL/DIV, so an MFHI/MFLO after a mult/div waits for it to finish: no hazard forwarding needed.

## Test plan
- MULT 0xFFFFFFFE x 0x00000003 (signed), MUL_LAT = 2, mul_res model returns the product after 2 cycles -> busy high in cycles 1–2; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA in cycle 3; op_ready low in cycles 1–2.
- DIVU 100 / 7, divider model asserts div_done after 32 cycles -> exactly one div_start pulse in cycle 1; lo = 14, hi = 2 in the cycle after div_done; MFLO accepted then returns rd_data = 14.
- DIV with op_src2 = 0, hi = 0x11, lo = 0x22 beforehand -> no div_start, busy stays 0, hi/lo unchanged, op_ready high in the next cycle.
- DIV in flight, flush in the same cycle as div_done -> div_cancel pulse, no HI/LO write, IDLE next cycle. Separately, flush in IDLE with op_valid MTLO -> op_ready 0, lo unchanged.
- MTHI 0xDEADBEEF in cycle 0, MFHI in cycle 1 -> rd_data = 0xDEADBEEF in cycle 1. MTLO 5 then MULTU 0x10000 x 0x10000 -> hi = 1, lo = 0.
- Assert resetn low mid-DIV (cycle 10) -> hi/lo/busy/div_start go to 0 immediately without a clock edge; after release, op_ready = 1 and a fresh MULT completes normally.
